// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: FSM states, widths and the PC type.
package pc_pkg;

    localparam int PC_W  = 10;
    localparam int IDX_W = 5;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for one RUN cycle: stall, then halt, then taken branch,
// then the end-of-program fault, then sequential increment.
module pc_next_sel #(
    parameter int PC_W     = 10,
    parameter int PROG_MAX = 1023
) (
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            halt_instr,
    input  logic            branch_en,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] lut_target,
    output logic [PC_W-1:0] next_pc,
    output logic            halt_hit,
    output logic            fault_hit
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_MAX);

    always_comb begin
        next_pc   = pc;
        halt_hit  = 1'b0;
        fault_hit = 1'b0;
        if (!stall) begin
            if (halt_instr) begin
                halt_hit = 1'b1;
            end else if (branch_en && branch_taken) begin
                // A taken branch is legal even from the last program word.
                next_pc = lut_target;
            end else if (pc == PC_LAST) begin
                fault_hit = 1'b1;
            end else begin
                next_pc = pc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Run/halt sequencer for the single-cycle core: owns the PC, the start/done
// handshake with the host, the sticky fault flag and a saturating run-cycle counter.
module pc_sequencer #(
    parameter int PC_W     = pc_pkg::PC_W,
    parameter int IDX_W    = pc_pkg::IDX_W,
    parameter int START_PC = 0,
    parameter int PROG_MAX = 1023,
    parameter int CYC_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt_instr,
    input  logic             Branch_en,
    input  logic             Branch_taken,
    input  logic [IDX_W-1:0] Lut_idx,
    output logic [IDX_W-1:0] Lut_addr,
    input  logic [PC_W-1:0]  Lut_target,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    input  logic             Done_ack,
    output logic             Fault,
    output logic [CYC_W-1:0] Cycle_count
);

    import pc_pkg::*;

    localparam logic [PC_W-1:0] START_PC_P = PC_W'(START_PC);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;

    logic [PC_W-1:0]   sel_next_pc;
    logic              sel_halt;
    logic              sel_fault;

    pc_next_sel #(
        .PC_W     (PC_W),
        .PROG_MAX (PROG_MAX)
    ) u_next_sel (
        .pc           (pc_q),
        .stall        (Stall),
        .halt_instr   (Halt_instr),
        .branch_en    (Branch_en),
        .branch_taken (Branch_taken),
        .lut_target   (Lut_target),
        .next_pc      (sel_next_pc),
        .halt_hit     (sel_halt),
        .fault_hit    (sel_fault)
    );

    // The LUT is combinational, so its target is consumed in the same cycle.
    always_comb begin
        Lut_addr = (state_q == RUN) ? Lut_idx : '0;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        running_d = running_q;
        done_d    = done_q;
        fault_d   = fault_q;
        cyc_d     = cyc_q;
        case (state_q)
            IDLE: begin
                pc_d      = START_PC_P;
                running_d = 1'b0;
                done_d    = 1'b0;
                if (Start) begin
                    state_d   = RUN;
                    running_d = 1'b1;
                    cyc_d     = '0;
                    fault_d   = 1'b0;
                end
            end
            RUN: begin
                cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
                pc_d  = sel_next_pc;
                if (sel_halt || sel_fault) begin
                    state_d   = DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end
                if (sel_fault) begin
                    fault_d = 1'b1;
                end
            end
            DONE: begin
                // Fault and the cycle count survive the ack so the host can still read them.
                if (Done_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    pc_d    = START_PC_P;
                end
            end
            default: begin
                state_d   = IDLE;
                pc_d      = START_PC_P;
                running_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC_P;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
            cyc_q     <= cyc_d;
        end
    end

    assign PC          = pc_q;
    assign Running     = running_q;
    assign Done        = done_q;
    assign Fault       = fault_q;
    assign Cycle_count = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a driver feeds a behavioural model that queues
// expected outputs, and an independent monitor compares them against the DUT each cycle.
module tb_pc_sequencer;

    localparam int CYC_W   = 4;
    localparam int CYC_MAX = (1 << CYC_W) - 1;

    typedef struct {
        int         edge_n;
        logic [9:0] pc;
        logic       running;
        logic       done;
        logic       fault;
        logic [3:0] cyc;
    } exp_t;

    typedef struct {
        int         edge_n;
        logic [4:0] addr;
    } lut_exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       halt_instr = 1'b0;
    logic       branch_en = 1'b0;
    logic       branch_taken = 1'b0;
    logic [4:0] lut_idx = '0;
    logic [4:0] lut_addr;
    logic [9:0] lut_target;
    logic [9:0] pc;
    logic       running;
    logic       done;
    logic       done_ack = 1'b0;
    logic       fault;
    logic [3:0] cycle_count;

    logic [9:0] lut_mem [32];

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;

    exp_t     exp_q[$];
    lut_exp_t lut_q[$];

    // Behavioural model of the sequencer, tracked as plain integers and flags.
    int m_pc = 0;
    bit m_running = 0;
    bit m_done = 0;
    bit m_fault = 0;
    int m_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    assign lut_target = lut_mem[lut_addr];

    pc_sequencer #(
        .PC_W     (10),
        .IDX_W    (5),
        .START_PC (0),
        .PROG_MAX (1023),
        .CYC_W    (CYC_W)
    ) dut (
        .Clk          (clk),
        .Reset        (reset),
        .Start        (start),
        .Stall        (stall),
        .Halt_instr   (halt_instr),
        .Branch_en    (branch_en),
        .Branch_taken (branch_taken),
        .Lut_idx      (lut_idx),
        .Lut_addr     (lut_addr),
        .Lut_target   (lut_target),
        .PC           (pc),
        .Running      (running),
        .Done         (done),
        .Done_ack     (done_ack),
        .Fault        (fault),
        .Cycle_count  (cycle_count)
    );

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s edge=%0d got=%0d want=%0d", nm, edge_cnt, got, want);
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit sl, input bit hl,
                              input bit be, input bit bt, input int idx, input bit ack);
        if (rst) begin
            m_running = 0; m_done = 0; m_pc = 0; m_fault = 0; m_cyc = 0;
        end else if (m_running) begin
            m_cyc = (m_cyc < CYC_MAX) ? m_cyc + 1 : CYC_MAX;
            if (!sl) begin
                if (hl) begin
                    m_running = 0; m_done = 1;
                end else if (be && bt) begin
                    m_pc = int'(lut_mem[idx]);
                end else if (m_pc == 1023) begin
                    m_fault = 1; m_running = 0; m_done = 1;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
        end else if (m_done) begin
            if (ack) begin
                m_done = 0; m_pc = 0;
            end
        end else begin
            m_pc = 0;
            if (st) begin
                m_running = 1; m_cyc = 0; m_fault = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit st, input bit sl, input bit hl,
                                 input bit be, input bit bt, input int idx, input bit ack);
        exp_t     e;
        lut_exp_t l;
        @(posedge clk);
        #1;
        reset = rst; start = st; stall = sl; halt_instr = hl;
        branch_en = be; branch_taken = bt; lut_idx = 5'(idx); done_ack = ack;
        l.edge_n = edge_cnt;
        l.addr   = m_running ? 5'(idx) : 5'd0;
        lut_q.push_back(l);
        model_step(rst, st, sl, hl, be, bt, idx, ack);
        e.edge_n  = edge_cnt + 1;
        e.pc      = 10'(m_pc);
        e.running = m_running;
        e.done    = m_done;
        e.fault   = m_fault;
        e.cyc     = 4'(m_cyc);
        exp_q.push_back(e);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the driver queued for the edge that just passed.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (lut_q.size() > 0 && lut_q[0].edge_n == edge_cnt) begin
                lut_exp_t l;
                l = lut_q.pop_front();
                check("lut_addr", 16'(lut_addr), 16'(l.addr));
            end
            if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                check("pc", 16'(pc), 16'(e.pc));
                check("running", 16'(running), 16'(e.running));
                check("done", 16'(done), 16'(e.done));
                check("fault", 16'(fault), 16'(e.fault));
                check("cycle_count", 16'(cycle_count), 16'(e.cyc));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            lut_mem[i] = ((i % 4) == 0) ? 10'(1018 + (i % 6)) : 10'($urandom_range(0, 1023));
        end
        lut_mem[1] = 10'd179;
        lut_mem[2] = 10'd1023;
        lut_mem[3] = 10'd7;
        lut_mem[4] = 10'd314;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        plain(5);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        plain(3);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
        plain(1);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        plain(3);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
        plain(3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        plain(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        plain(1);

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 2, 0);
        plain(2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        plain(2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 4, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        plain(1);

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        plain(20);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 31)),
                          $urandom_range(0, 4) == 0);
        end

        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 16'(exp_q.size() + lut_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
